alu_issue: RTL

- Instruction issue unit that feeds the 4-stage pipelined ALU.
- Buffers incoming instruction tuples {rs1, rs2, rd, func, addr} in a FIFO and issues one per clock on the ALU's operand/control inputs.
- Detects read-after-write hazards against results still in flight and inserts NOP bubbles until the result has reached the register bank.
- Rejects function codes the ALU does not implement.

---
 rtl/alu_issue.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/alu_issue.sv
// ---------------------------------------------------------------------------
// alu_issue: instruction issue unit in front of the 4-stage pipelined ALU.
//
// Incoming {rs1, rs2, rd, func, addr} tuples are buffered in a FIFO. The
// unit issues at most one tuple per clock onto registered ALU inputs. While
// the head reads a register that is still in flight, it holds the head and
// sends NOP bubbles. Function codes 12..15 are dropped with a one-cycle
// err_illegal pulse.
//
// Optional build macro: ALU_ISSUE_STATS_EN adds the issued_cnt and stall_cnt
// counters. Both are cleared only by rst and saturate at 16'hFFFF.
//
// Ports:
//   clk1                        clock, every register uses its rising edge
//   rst                         synchronous active-high reset (highest priority)
//   flush                       synchronous clear of queued and pending state
//   in_valid / in_ready         input handshake (see below)
//   in_rs1/in_rs2/in_rd/in_func 4-bit instruction fields
//   in_addr                     8-bit result memory address
//   rs1/rs2/rd/func/addr        registered operand/control outputs to the ALU
//   issue_valid                 1 = real instruction on the outputs, 0 = bubble
//   err_illegal                 one-cycle pulse when an instruction is dropped
//   busy                        FIFO non-empty or any pending entry valid
//   issued_cnt, stall_cnt       (ALU_ISSUE_STATS_EN only) statistics counters
//
// Handshake: a tuple is accepted on a rising edge of clk1 where
// in_valid && in_ready. in_ready is low while the FIFO is full (even if a pop
// happens in the same cycle) and while flush is high. in_valid must not
// depend on in_ready.
// ---------------------------------------------------------------------------
module alu_issue #(
    parameter int          DEPTH      = 8,
    parameter int          PIPE_DEPTH = 2,
    parameter logic [3:0]  NOP_RD     = 4'd0,
    parameter logic [7:0]  NOP_ADDR   = 8'd255
) (
    input  logic        clk1,
    input  logic        rst,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_rs1,
    input  logic [3:0]  in_rs2,
    input  logic [3:0]  in_rd,
    input  logic [3:0]  in_func,
    input  logic [7:0]  in_addr,
    output logic [3:0]  rs1,
    output logic [3:0]  rs2,
    output logic [3:0]  rd,
    output logic [3:0]  func,
    output logic [7:0]  addr,
    output logic        issue_valid,
    output logic        err_illegal,
`ifdef ALU_ISSUE_STATS_EN
    output logic [15:0] issued_cnt,
    output logic [15:0] stall_cnt,
`endif
    output logic        busy
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [3:0] NOP_FUNC = 4'd3;

    typedef struct packed {
        logic [3:0] rs1;
        logic [3:0] rs2;
        logic [3:0] rd;
        logic [3:0] func;
        logic [7:0] addr;
    } instr_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        STALL = 2'd2
    } state_t;

    // FSM state is a named signal so checkers can bind to it directly.
    state_t state, next_state;

    instr_t          mem [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count;

    // Pending scoreboard: entry i holds the destination of the real
    // instruction issued i+1 edges ago.
    logic [PIPE_DEPTH-1:0] pend_v;
    logic [3:0]            pend_rd [PIPE_DEPTH];

    instr_t head;
    logic   full, push, pop, issue, drop, hazard, haz_bubble, illegal;

    assign head     = mem[rd_ptr];
    assign full     = (count == CW'(DEPTH));
    assign in_ready = !full && !flush;
    assign push     = in_valid && in_ready;
    assign illegal  = (head.func >= 4'd12);
    assign busy     = (count != '0) || (|pend_v);

    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < PIPE_DEPTH; i++) begin
            if (pend_v[i] && (pend_rd[i] == head.rs1 || pend_rd[i] == head.rs2))
                hazard = 1'b1;
        end
    end

    // RUN and STALL evaluate the head the same way; STALL only records
    // that the previous cycle was a hazard bubble. Issuing on the first
    // hazard-free STALL cycle gives exactly PIPE_DEPTH bubbles between a
    // dependent back-to-back pair.
    always_comb begin
        next_state = state;
        pop        = 1'b0;
        issue      = 1'b0;
        drop       = 1'b0;
        haz_bubble = 1'b0;
        case (state)
            IDLE: begin
                if (push) next_state = RUN;
            end
            RUN, STALL: begin
                if (illegal) begin
                    pop  = 1'b1;
                    drop = 1'b1;
                end else if (hazard) begin
                    haz_bubble = 1'b1;
                    next_state = STALL;
                end else begin
                    pop   = 1'b1;
                    issue = 1'b1;
                end
                if (pop)
                    next_state = (count == CW'(1) && !push) ? IDLE : RUN;
            end
            default: next_state = IDLE;
        endcase
    end

    // Storage without reset: contents are only meaningful under count.
    always_ff @(posedge clk1) begin
        if (push) mem[wr_ptr] <= '{in_rs1, in_rs2, in_rd, in_func, in_addr};
        pend_rd[0] <= head.rd;
        for (int i = 1; i < PIPE_DEPTH; i++) pend_rd[i] <= pend_rd[i-1];
    end

    always_ff @(posedge clk1) begin
        if (rst || flush) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            state       <= IDLE;
            pend_v      <= '0;
            rs1         <= 4'd0;
            rs2         <= 4'd0;
            rd          <= NOP_RD;
            func        <= NOP_FUNC;
            addr        <= NOP_ADDR;
            issue_valid <= 1'b0;
            err_illegal <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            state     <= next_state;
            pend_v[0] <= issue;
            for (int i = 1; i < PIPE_DEPTH; i++) pend_v[i] <= pend_v[i-1];
            if (issue) begin
                rs1  <= head.rs1;
                rs2  <= head.rs2;
                rd   <= head.rd;
                func <= head.func;
                addr <= head.addr;
            end else begin
                rs1  <= 4'd0;
                rs2  <= 4'd0;
                rd   <= NOP_RD;
                func <= NOP_FUNC;
                addr <= NOP_ADDR;
            end
            issue_valid <= issue;
            err_illegal <= drop;
        end
    end

`ifdef ALU_ISSUE_STATS_EN
    // Cleared by rst only; flush leaves the statistics intact.
    always_ff @(posedge clk1) begin
        if (rst) begin
            issued_cnt <= '0;
            stall_cnt  <= '0;
        end else begin
            if (issue && !flush && issued_cnt != 16'hFFFF)
                issued_cnt <= issued_cnt + 16'd1;
            if (haz_bubble && !flush && stall_cnt != 16'hFFFF)
                stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule
